// File: rtl/pezaris_seq_mult_pkg.sv
// pezaris_pkg: shared state type and sizing helpers for the Pezaris multiplier.
// Mode select (signed/unsigned) is added by defining PEZARIS_SEQ_MULT_MODE_EN.
package pezaris_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      RESOLVE,
      DONE
   } state_t;

   function automatic int prod_w(input int w);
      return 2 * w;
   endfunction

   function automatic int cnt_w(input int w);
      return $clog2(w);
   endfunction

   // Each negated cell contributes ~x - 1; the 2*(w-1) hidden -1 terms
   // sum to -(2^(2w-1)) + 2^w, i.e. bits w and 2w-1 modulo 2^(2w).
   function automatic logic [63:0] sign_corr(input int w);
      logic [63:0] c;
      c = '0;
      c[w] = 1'b1;
      c[2*w-1] = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pezaris_seq_mult_csa_row.sv
// pezaris_csa_row: one row of full adders for the sequential Pezaris multiplier.
// typ[j]=1 makes cell j a type-1 cell whose partial-product term enters negated.
module pezaris_csa_row
   import pezaris_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] a,
   input  logic             bk,
   input  logic [WIDTH-1:0] typ,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] c
);

   logic [WIDTH-1:0] pp;

   // Gate the row's partial product, then reduce three vectors to sum/carry
   always_comb begin
      pp = (a & {WIDTH{bk}}) ^ typ;
      s  = x ^ y ^ pp;
      c  = (x & y) | (x & pp) | (y & pp);
   end

endmodule

// File: rtl/pezaris_seq_mult.sv
// pezaris_seq_mult: iterative two's-complement multiplier, one carry-save row per cycle.
// Define PEZARIS_SEQ_MULT_MODE_EN to add in_signed (runtime signed/unsigned select).
module pezaris_seq_mult
   import pezaris_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
`ifdef PEZARIS_SEQ_MULT_MODE_EN
   input  logic               in_signed,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic               busy
);

   localparam int PW = prod_w(WIDTH);
   localparam int CW = cnt_w(WIDTH);
   localparam logic [63:0] CORR_ALL = sign_corr(WIDTH);
   localparam logic [PW-1:0] CORR = CORR_ALL[PW-1:0];

   state_t state, state_n;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [PW-1:0]    sum_q;
   logic [PW-1:0]    carry_q;
   logic [PW-1:0]    sum_n;
   logic [PW-1:0]    carry_n;
   logic [CW-1:0]    k_q;
   logic [CW:0]      kx;
   logic [CW:0]      k1;

   logic [WIDTH-1:0] row_x;
   logic [WIDTH-1:0] row_y;
   logic [WIDTH-1:0] row_t;
   logic [WIDTH-1:0] row_s;
   logic [WIDTH-1:0] row_c;

   logic last;
   logic accept;
   logic sgn;
   logic sgn_in;

`ifdef PEZARIS_SEQ_MULT_MODE_EN
   logic sgn_q;

   assign sgn_in = in_signed;
   assign sgn    = sgn_q;

   // Operation mode captured with the operands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sgn_q <= 1'b0;
      end else if (accept) begin
         sgn_q <= in_signed;
      end
   end
`else
   assign sgn_in = 1'b1;
   assign sgn    = 1'b1;
`endif

   assign in_ready = rst_n && (state == IDLE);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;
   assign last     = (k_q == CW'(WIDTH - 1));

   // Next-state logic for the operation sequence
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (accept) state_n = ACCUM;
         end
         ACCUM: begin
            if (last) state_n = RESOLVE;
         end
         RESOLVE: begin
            state_n = DONE;
         end
         DONE: begin
            if (out_valid && out_ready) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Select the active column window and the cell types for row k
   always_comb begin
      kx    = {1'b0, k_q};
      k1    = kx + 1'b1;
      row_x = sum_q[kx +: WIDTH];
      row_y = carry_q[kx +: WIDTH];
      row_t = '0;
      if (sgn) begin
         if (last) begin
            row_t = {1'b0, {(WIDTH-1){1'b1}}};
         end else begin
            row_t = {1'b1, {(WIDTH-1){1'b0}}};
         end
      end
   end

   pezaris_csa_row #(
      .WIDTH (WIDTH)
   ) u_row (
      .x   (row_x),
      .y   (row_y),
      .a   (a_q),
      .bk  (b_q[k_q]),
      .typ (row_t),
      .s   (row_s),
      .c   (row_c)
   );

   // Write the row back: sums in place, carries one column up
   always_comb begin
      sum_n   = sum_q;
      carry_n = carry_q;
      sum_n[kx +: WIDTH]   = row_s;
      carry_n[kx +: WIDTH] = '0;
      carry_n[k1 +: WIDTH] = row_c;
   end

   // State register, datapath registers and output handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         carry_q   <= '0;
         k_q       <= '0;
         out_p     <= '0;
         out_valid <= 1'b0;
      end else begin
         state <= state_n;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  a_q     <= in_a;
                  b_q     <= in_b;
                  sum_q   <= sgn_in ? CORR : '0;
                  carry_q <= '0;
                  k_q     <= '0;
               end
            end
            ACCUM: begin
               sum_q   <= sum_n;
               carry_q <= carry_n;
               k_q     <= k_q + 1'b1;
            end
            RESOLVE: begin
               out_p <= sum_q + carry_q;
            end
            DONE: begin
               out_valid <= !(out_valid && out_ready);
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pezaris_seq_mult.sv
// tb_pezaris_seq_mult: self-checking bench for pezaris_seq_mult (WIDTH=8).
// Mode tests are included when PEZARIS_SEQ_MULT_MODE_EN is defined.
`timescale 1ns/1ps
module tb_pezaris_seq_mult;

   localparam int W  = 8;
   localparam int PW = 2 * W;
`ifdef PEZARIS_SEQ_MULT_MODE_EN
   localparam bit HAS_MODE = 1'b1;
`else
   localparam bit HAS_MODE = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out_p;
   logic          busy;
`ifdef PEZARIS_SEQ_MULT_MODE_EN
   logic          in_signed;
`endif

   int   vectors;
   int   miscompares;
   logic cur_sgn;

   pezaris_seq_mult #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
`ifdef PEZARIS_SEQ_MULT_MODE_EN
      .in_signed (in_signed),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic eff_sgn(input logic s);
      return s || !HAS_MODE;
   endfunction

   // Reference: plain integer product, truncated to the product width
   function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic sgn);
      longint r;
      if (sgn) r = longint'($signed(a)) * longint'($signed(b));
      else     r = longint'(a) * longint'(b);
      return r[PW-1:0];
   endfunction

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, output bit to);
      int n;
      @(negedge clk);
      in_a     = a;
      in_b     = b;
      cur_sgn  = eff_sgn(s);
`ifdef PEZARIS_SEQ_MULT_MODE_EN
      in_signed = s;
`endif
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      to = !in_ready;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
`ifdef PEZARIS_SEQ_MULT_MODE_EN
      in_signed = 1'($urandom);
`endif
   endtask

   task automatic wait_valid(output logic [PW-1:0] p, output int lat,
                             output bit to);
      lat = 0;
      to  = 1'b1;
      p   = '0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            to  = 1'b0;
            p   = out_p;
            break;
         end
      end
   endtask

   task automatic drain();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
`ifdef PEZARIS_SEQ_MULT_MODE_EN
      in_signed = 1'b1;
`endif
      repeat (2) @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      vectors++;
      if (out_p !== '0) begin
         miscompares++;
         $display("FAIL reset_out_p: got %h want 0", out_p);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_busy: got %b want 0", busy);
      end
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({in_ready, busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL release_idle: in_ready/busy got %b want 10",
                  {in_ready, busy});
      end
   endtask

   task automatic test_directed();
      logic [W-1:0]  ta[3];
      logic [W-1:0]  tb_[3];
      logic [PW-1:0] te[3];
      logic [PW-1:0] p;
      int            lat;
      bit            to;
      ta  = '{8'd3, 8'h80, 8'h7F};
      tb_ = '{8'd5, 8'h80, 8'h80};
      te  = '{16'h000F, 16'h4000, 16'hC080};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issue(ta[i], tb_[i], 1'b1, to);
         wait_valid(p, lat, to);
         vectors++;
         if (p !== te[i]) begin
            miscompares++;
            $display("FAIL directed_p[%0d]: got %h want %h", i, p, te[i]);
         end
         vectors++;
         if (lat != W + 2) begin
            miscompares++;
            $display("FAIL directed_latency[%0d]: got %0d want %0d",
                     i, lat, W + 2);
         end
         drain();
         vectors++;
         if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL directed_handshake[%0d]: got %b want 01",
                     i, {out_valid, in_ready});
         end
      end
   endtask

   task automatic test_backpressure();
      logic [PW-1:0] p;
      logic [PW-1:0] exp;
      int            lat;
      bit            to;
      out_ready = 1'b0;
      issue(8'hFB, 8'd7, 1'b1, to);
      exp = ref_mul(8'hFB, 8'd7, cur_sgn);
      wait_valid(p, lat, to);
      vectors++;
      if (p !== exp) begin
         miscompares++;
         $display("FAIL bp_p: got %h want %h", p, exp);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = 1'($urandom);
         in_a     = W'($urandom);
         in_b     = W'($urandom);
         vectors++;
         if ({out_valid, in_ready, out_p} !== {1'b1, 1'b0, exp}) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: valid/ready/p got %b/%b/%h want 1/0/%h",
                     i, out_valid, in_ready, out_p, exp);
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         miscompares++;
         $display("FAIL bp_release: valid/ready/busy got %b want 010",
                  {out_valid, in_ready, busy});
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_no_accept: busy got %b want 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      logic [PW-1:0] p;
      int            lat;
      int            seen;
      bit            to;
      out_ready = 1'b1;
      issue(8'h55, 8'h33, 1'b1, to);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({out_valid, busy, in_ready} !== 3'b000 || out_p !== '0) begin
         miscompares++;
         $display("FAIL midreset_outputs: valid/busy/ready got %b p %h want 000 p 0",
                  {out_valid, busy, in_ready}, out_p);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < W + 6; i++) begin
         @(posedge clk);
         #1;
         if (out_valid || busy) seen++;
      end
      vectors++;
      if (seen != 0) begin
         miscompares++;
         $display("FAIL midreset_abort: got %0d active cycles want 0", seen);
      end
      issue(8'hF9, 8'd9, 1'b1, to);
      wait_valid(p, lat, to);
      vectors++;
      if (p !== 16'hFFC1 || lat != W + 2) begin
         miscompares++;
         $display("FAIL midreset_next: got p %h lat %0d want p ffc1 lat %0d",
                  p, lat, W + 2);
      end
      drain();
   endtask

   task automatic test_random();
      logic [W-1:0]  cv[5];
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic          s;
      logic [PW-1:0] p;
      logic [PW-1:0] exp;
      logic          r;
      int            lat;
      bit            to;
      cv = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
      for (int n = 0; n < 145; n++) begin
         if (n < 25) begin
            a = cv[n / 5];
            b = cv[n % 5];
         end else begin
            a = W'($urandom);
            b = W'($urandom);
         end
         s = HAS_MODE ? 1'($urandom) : 1'b1;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         out_ready = 1'($urandom);
         issue(a, b, s, to);
         exp = ref_mul(a, b, cur_sgn);
         wait_valid(p, lat, to);
         vectors++;
         if (p !== exp || lat != W + 2) begin
            miscompares++;
            $display("FAIL rand_p[%0d] a=%h b=%h s=%b: got %h lat %0d want %h lat %0d",
                     n, a, b, cur_sgn, p, lat, exp, W + 2);
         end
         r = 1'b0;
         for (int i = 0; i < 40 && !r; i++) begin
            @(negedge clk);
            out_ready = (i > 8) ? 1'b1 : 1'($urandom);
            r = out_ready;
            vectors++;
            if ({out_valid, out_p} !== {1'b1, exp}) begin
               miscompares++;
               $display("FAIL rand_stall[%0d]: valid/p got %b/%h want 1/%h",
                        n, out_valid, out_p, exp);
            end
            @(posedge clk);
            #1;
         end
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_drain[%0d]: out_valid got %b want 0",
                     n, out_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0]  qa[6];
      logic [W-1:0]  qb[6];
      logic [PW-1:0] expq[$];
      logic [PW-1:0] e;
      int            idx;
      int            got;
      int            last_out;
      for (int i = 0; i < 6; i++) begin
         qa[i] = W'($urandom);
         qb[i] = W'($urandom);
      end
      out_ready = 1'b1;
      idx       = 0;
      got       = 0;
      last_out  = -100;
      for (int cyc = 0; cyc < 300 && got < 6; cyc++) begin
         @(negedge clk);
         if (idx < 6) begin
            in_a     = qa[idx];
            in_b     = qb[idx];
            cur_sgn  = eff_sgn(1'b1);
`ifdef PEZARIS_SEQ_MULT_MODE_EN
            in_signed = 1'b1;
`endif
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid && out_ready) begin
            e = (expq.size() > 0) ? expq.pop_front() : 'x;
            vectors++;
            if (out_p !== e || cyc - last_out < W + 3) begin
               miscompares++;
               $display("FAIL b2b_p[%0d]: got %h gap %0d want %h gap>=%0d",
                        got, out_p, cyc - last_out, e, W + 3);
            end
            last_out = cyc;
            got++;
         end
         if (in_valid && in_ready) begin
            expq.push_back(ref_mul(qa[idx], qb[idx], cur_sgn));
            idx++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      vectors++;
      if (got != 6) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d products want 6", got);
      end
      repeat (W + 6) @(negedge clk);
   endtask

`ifdef PEZARIS_SEQ_MULT_MODE_EN
   task automatic test_mode();
      logic [PW-1:0] p;
      int            lat;
      bit            to;
      out_ready = 1'b1;
      issue(8'hFF, 8'hFF, 1'b0, to);
      wait_valid(p, lat, to);
      vectors++;
      if (p !== 16'hFE01) begin
         miscompares++;
         $display("FAIL mode_unsigned: got %h want fe01", p);
      end
      drain();
      issue(8'hFF, 8'hFF, 1'b1, to);
      wait_valid(p, lat, to);
      vectors++;
      if (p !== 16'h0001) begin
         miscompares++;
         $display("FAIL mode_signed: got %h want 0001", p);
      end
      drain();
   endtask
`endif

   initial begin
      vectors     = 0;
      miscompares = 0;
      cur_sgn     = 1'b1;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
`ifdef PEZARIS_SEQ_MULT_MODE_EN
      test_mode();
`endif
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
